// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Target end of the pipeline's data-memory port. This is a word-organised memory with a
//   valid/ready request channel and a valid/ready response channel. Each access is followed
//   by LATENCY wait states. Writes are merged per byte. Accesses that are misaligned or out
//   of range are answered with an error.
//
// Parameters
//   DEPTH    number of 32-bit words (power of 2, 4..1024)
//   LATENCY  wait-state cycles between request accept and response (0..15)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake (ready only while idle)
//   req_write, req_addr,
//   req_wdata, req_be           request payload (byte address, byte enables)
//   rsp_valid / rsp_ready       response handshake
//   rsp_rdata, rsp_error        registered response payload, stable while rsp_valid
//   busy                        transaction in flight, used as the pipeline stall
module data_mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [3:0]  CntInit   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] AddrLimit = 32'(4 * DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        accept, commit;

  logic [31:0] mem_q [DEPTH];

  // The commit source is the live request when LATENCY is 0, because the commit then happens
  // on the accept edge. Otherwise it is the captured request.
  logic          c_write;
  logic [31:0]   c_addr, c_wdata;
  logic [3:0]    c_be;
  logic [AW-1:0] c_idx;
  logic          c_err;
  logic          mem_we;

  always_comb begin
    if (state_q == StIdle) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end else begin
      c_write = write_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end
  end

  assign c_idx = c_addr[AW+1:2];
  assign c_err = (c_addr[1:0] != 2'b00) || (c_addr >= AddrLimit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = CntInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      rdata_d = (c_err || c_write) ? 32'd0 : mem_q[c_idx];
      error_d = c_err;
    end
  end

  // Gate the write with rst_n. With LATENCY == 0, a request held during reset must not commit.
  assign mem_we = commit && c_write && !c_err && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      error_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_be[i]) mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder (target) end of the pipeline's data-memory port: a word-organised data memory with a valid/ready request channel and a valid/ready response channel.
- Inserts a configurable number of wait states, replacing the zero-latency combinational data memory in the MEM stage.
- Drives a busy flag the pipeline uses to stall.
- Merges byte-enabled writes and flags misaligned or out-of-range accesses.

Parameters:
DEPTH, 64, number of 32-bit words; power of 2, 4..1024
LATENCY, 2, wait-state cycles between request accept and response; 0..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept; high only in IDLE
req_write  in  1  1 = write, 0 = read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_be  in  4  byte enables; bit i covers bits [8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  initiator takes response
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_error  out  1  access was misaligned or out of range
busy  out  1  transaction in flight (state != IDLE); used as pipeline stall

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, req_ready=1.
  - Array contents are not cleared.
- Outputs vs. state:
  - req_ready=1 exactly in IDLE; busy=1 in WAIT and RESP.
  - rsp_valid=1 exactly in RESP; rsp_rdata and rsp_error are registered and stable throughout RESP.
- Accept:
  - Occurs at an edge in IDLE with req_valid=1.
  - Captures req_write, req_addr, req_wdata and req_be.
  - Goes to WAIT with counter=LATENCY-1 if LATENCY>0, otherwise goes directly to RESP with commit on that same edge.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 0, the commit happens and state goes to RESP.
  - rsp_valid is therefore first high in the cycle following accept edge + LATENCY edges.
- Commit:
  - Word index = addr[log2(DEPTH)+1:2].
  - Error if addr[1:0]!=0 or addr >= 4*DEPTH. On error: no array change, rsp_rdata=0, rsp_error=1.
  - Write: each byte with be[i]=1 is replaced; others are kept. rsp_rdata=0, rsp_error=0. be=4'b0000 is legal: no change, normal response.
  - Read: rsp_rdata = full word at index (be ignored), rsp_error=0.
- RESP:
  - Held until an edge with rsp_ready=1, then state goes to IDLE and rsp_rdata/rsp_error clear to 0.
  - rsp_ready outside RESP is ignored.
- Throughput:
  - Minimum one IDLE cycle between transactions.
  - Back-to-back requests from a held req_valid are accepted every LATENCY+2 cycles when rsp_ready is held at 1.
- req_valid and other request inputs are ignored outside IDLE; captured values are not affected by input changes after accept.
- Reset mid-transaction: the transaction is dropped with no response.
  - A write reset before its commit edge never modifies the array.
  - A write whose commit edge has passed persists.
- Read-after-write ordering: a read accepted after a completed write returns the written data.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10 with be=4'hF, rsp_ready=1 (LATENCY=2) -> rsp_valid high exactly 3 cycles after the accept edge, rsp_error=0. Read addr 0x10 -> rsp_rdata=0xDEADBEEF; busy high from accept until the response edge.
- Write 0x11223344 to addr 0x20 with be=4'hF, then write 0xAABBCCDD to addr 0x20 with be=4'b0101. Read addr 0x20 -> rsp_rdata=0x11BB33DD.
- Read addr 0x22 (misaligned) and read addr 0x100 (DEPTH=64) -> rsp_error=1, rsp_rdata=0. Write 0xFFFFFFFF to addr 0x102 -> rsp_error=1; a subsequent read of 0x100 still errors and no in-range word changes.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_error stay stable, req_ready=0, and a new req_valid is not accepted. Raising rsp_ready -> IDLE next cycle and req_ready=1.
- Assert rst_n=0 during WAIT of a write of 0x55 to addr 0x30 (previously 0x0) -> all outputs reset immediately with no response. Read addr 0x30 after reset -> 0x0.
- Rerun with LATENCY=0 and req_valid/rsp_ready held high for 4 reads -> each rsp_valid appears the cycle after its accept, and one accept occurs every 2 cycles.
